// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned STAT_W = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    sum    = '0;
    pos    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // Explicit wrap at NUM_REQ so non-power-of-two counts scan correctly.
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (sum >= NREQ) sum = sum - NREQ;
      pos = sum[IDX_W-1:0];
      if (!any && req[pos]) begin
        any         = 1'b1;
        onehot[pos] = 1'b1;
        index       = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bounded bursts.
// Optional statistics counters enabled with `define ARB_STATS_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WORD      = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*WORD-1:0] req_word,
  input  logic                    full,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    wen,
  output logic [WORD-1:0]         w_word
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]       words_total,
  output logic [STAT_W-1:0]       stall_cycles
`endif
);

  localparam int unsigned IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
  localparam int unsigned BC_W  = (clog2(MAX_BURST + 1) < 1) ? 1 : clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               req_g;
  logic [WORD-1:0]    word_g;
  logic [IDX_W-1:0]   next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    ack         = '0;
    wen         = 1'b0;
    w_word      = '0;
    req_g       = 1'b0;
    word_g      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        req_g  = req[i];
        word_g = req_word[i*WORD +: WORD];
      end
    end
    next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d     = pick_onehot;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        w_word = word_g;
        // A dropped request releases even when full is also high.
        if (!req_g) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end else if (!full) begin
          ack         = grant_q;
          wen         = 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == BURST_LAST) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      ack = '0;
      wen = 1'b0;
    end
  end

  assign grant = grant_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] words_total_q, words_total_d;
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    words_total_d  = words_total_q;
    stall_cycles_d = stall_cycles_q;
    if (wen) words_total_d = words_total_q + 1'b1;
    if (state_q == GRANT && req_g && full && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_total_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      words_total_q  <= words_total_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign words_total  = words_total_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed, table-driven bench for fifo_write_arbiter (NUM_REQ=4, WORD=8, MAX_BURST=4).
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        full;
  logic [3:0]  req;
  logic [31:0] req_word;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        wen;
  logic [7:0]  w_word;
`ifdef ARB_STATS_EN
  logic [15:0] words_total;
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ   (4),
    .WORD      (8),
    .MAX_BURST (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_word     (req_word),
    .full         (full),
    .ack          (ack),
    .grant        (grant),
    .wen          (wen),
    .w_word       (w_word)
`ifdef ARB_STATS_EN
    ,
    .words_total  (words_total),
    .stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       wen;
    logic [7:0] word;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic f,
                     input logic [3:0] g, input logic [3:0] a, input logic w, input logic [7:0] d);
    vec_t v;
    v.rst = r; v.req = q; v.full = f; v.grant = g; v.ack = a; v.wen = w; v.word = d;
    tbl.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic r, input logic [3:0] q, input logic f);
    @(negedge clk);
    rst = r; req = q; full = f;
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   nxt;
    int   exp_rx;
    int   acks;
    bit   pending;
    logic exp_wen;

    rst = 1'b1; req = '0; full = 1'b0; req_word = 32'h13121110;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_grant", grant, 4'h0);
    chk("reset_wen", wen, 1'b0);
    chk("reset_w_word", w_word, 8'h00);
    req = 4'hF; #1;
    chk("reset_ack_req_high", ack, 4'h0);
    chk("reset_wen_req_high", wen, 1'b0);

    // All four requesting: grant order 0,1,2,3 with 4 words each and one idle bubble.
    add(0, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 4; n++)
        add(0, 4'hF, 0, 4'(1 << k), 4'(1 << k), 1, 8'(8'h10 + k));
      add(0, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00);
    end
    add(0, 4'hF, 0, 4'h1, 4'h1, 1, 8'h10);
    add(0, 4'hF, 1, 4'h1, 4'h0, 0, 8'h10);
    for (int n = 0; n < 3; n++) add(0, 4'hF, 0, 4'h1, 4'h1, 1, 8'h10);
    add(0, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'hF, 0, 4'h2, 4'h2, 1, 8'h11);
    add(0, 4'hD, 0, 4'h2, 4'h0, 0, 8'h11);
    add(0, 4'hD, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'hD, 0, 4'h4, 4'h4, 1, 8'h12);
    add(0, 4'h9, 1, 4'h4, 4'h0, 0, 8'h12);
    add(0, 4'h9, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h9, 0, 4'h8, 4'h8, 1, 8'h13);
    add(0, 4'h0, 0, 4'h8, 4'h0, 0, 8'h13);
    add(0, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h4, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h4, 0, 4'h4, 4'h4, 1, 8'h12);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].full);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("tbl%0d_ack", i), ack, tbl[i].ack);
      chk($sformatf("tbl%0d_wen", i), wen, tbl[i].wen);
      chk($sformatf("tbl%0d_w_word", i), w_word, tbl[i].word);
    end

    // Reset mid-burst, then a fresh full-length burst to req0.
    do_reset();
    step(0, 4'h1, 0); chk("rmb_idle_grant", grant, 4'h0);
    step(0, 4'h1, 0); chk("rmb_ack_w1", ack, 4'h1);
    step(0, 4'h1, 0); chk("rmb_ack_w2", ack, 4'h1);
    step(1, 4'h1, 0); chk("rmb_rst_ack", ack, 4'h0); chk("rmb_rst_wen", wen, 1'b0);
    step(0, 4'h1, 0); chk("rmb_post_grant", grant, 4'h0); chk("rmb_post_wen", wen, 1'b0);
    for (int n = 0; n < 4; n++) begin
      step(0, 4'h1, 0);
      chk($sformatf("rmb_burst%0d_grant", n), grant, 4'h1);
      chk($sformatf("rmb_burst%0d_wen", n), wen, 1'b1);
    end
    step(0, 4'h1, 0); chk("rmb_burst_end_grant", grant, 4'h0);

    // Early release of req0 while req3 waits: next grant is req3.
    do_reset();
    step(0, 4'h9, 0); chk("er_idle", grant, 4'h0);
    step(0, 4'h9, 0); chk("er_w1", ack, 4'h1);
    step(0, 4'h9, 0); chk("er_w2", ack, 4'h1);
    step(0, 4'h8, 0); chk("er_drop_grant", grant, 4'h1); chk("er_drop_ack", ack, 4'h0);
    step(0, 4'h8, 0); chk("er_bubble", grant, 4'h0);
    step(0, 4'h8, 0); chk("er_next_grant", grant, 4'h8); chk("er_next_ack", ack, 4'h8);

    // Single producer req1 streaming words 1..8.
    do_reset();
    nxt = 1; exp_rx = 1; acks = 0; pending = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (pending) begin nxt++; pending = 0; end
      req_word[15:8] = 8'(nxt);
      rst = 0; full = 0; req = (nxt <= 8) ? 4'h2 : 4'h0;
      #1;
      exp_wen = !(c == 0 || c == 5 || c == 10);
      chk($sformatf("sp_wen_c%0d", c), wen, exp_wen);
      if (ack == 4'h2) acks++;
      if (wen) begin
        chk($sformatf("sp_word_c%0d", c), w_word, 8'(exp_rx));
        exp_rx++;
        pending = 1;
      end
    end
    chk("sp_ack_count", acks, 8);
    chk("sp_words_recv", exp_rx, 9);

    // full for 3 cycles after word 2 of req2.
    do_reset();
    nxt = 1; exp_rx = 1; pending = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (pending) begin nxt++; pending = 0; end
      req_word[23:16] = 8'(nxt);
      rst = 0; full = (c >= 3 && c <= 5); req = (nxt <= 4) ? 4'h4 : 4'h0;
      #1;
      exp_wen = (c == 1 || c == 2 || c == 6 || c == 7);
      chk($sformatf("fs_wen_c%0d", c), wen, exp_wen);
      if (full) begin
        chk($sformatf("fs_grant_c%0d", c), grant, 4'h4);
        chk($sformatf("fs_ack_c%0d", c), ack, 4'h0);
      end
      if (wen) begin
        chk($sformatf("fs_word_c%0d", c), w_word, 8'(exp_rx));
        exp_rx++;
        pending = 1;
      end
    end
    chk("fs_words_recv", exp_rx, 5);

`ifdef ARB_STATS_EN
    begin
      int writes;
      int stalls;
      do_reset();
      chk("st_reset_total", words_total, 16'h0);
      chk("st_reset_stall", stall_cycles, 16'h0);
      writes = 0; stalls = 0;
      for (int c = 0; c < 200 && writes < 20; c++) begin
        @(negedge clk);
        rst = 0; req = 4'h1;
        full = (stalls < 5 && grant == 4'h1 && (c % 3 == 1));
        #1;
        if (wen) writes++;
        if (grant == 4'h1 && full) stalls++;
      end
      step(0, 4'h0, 0);
      chk("st_writes_done", writes, 20);
      chk("st_words_total", words_total, 16'd20);
      chk("st_stall_cycles", stall_cycles, 16'd5);

      do_reset();
      step(0, 4'h1, 0);
      step(0, 4'h1, 0);
      force dut.words_total_q = 16'hFFFF;
      #1;
      release dut.words_total_q;
      chk("st_pre_wrap", words_total, 16'hFFFF);
      chk("st_wrap_wen", wen, 1'b1);
      step(0, 4'h1, 0);
      chk("st_wrap", words_total, 16'h0000);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
